// File: rtl/avg_pool_pkg.sv
// Shared types and width helpers for the average-pooling accumulator stage.
package avg_pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } pool_state_t;

  localparam int SHIFT_WIDTH = 5;

  // Product lanes arrive at twice the output lane width.
  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int min_acc_width(input int data_width, input int cnt_width);
    return 2 * data_width + cnt_width;
  endfunction

endpackage

// File: rtl/avg_pool_round_sat.sv
// One lane: rounding arithmetic right shift (half toward +inf) then signed saturation.
// Purely combinational; feeds the pooled-output register directly.
module avg_pool_round_sat
  import avg_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic [ACC_WIDTH-1:0]   sum,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [DATA_WIDTH-1:0]  result
);

  // Headroom for the rounding bias at any shift, so large shifts never lose the bias bit.
  localparam int EXT_W = ACC_WIDTH + (1 << SHIFT_WIDTH);

  logic signed [EXT_W-1:0] sum_ext;
  logic signed [EXT_W-1:0] bias;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] sat_max;
  logic signed [EXT_W-1:0] sat_min;

  assign sat_max = {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  assign sat_min = {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    sum_ext = {{(EXT_W-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
    bias    = '0;
    if (shift != '0) begin
      bias = EXT_W'(1) << (shift - SHIFT_WIDTH'(1));
    end
    rounded = (sum_ext + bias) >>> shift;

    result = rounded[DATA_WIDTH-1:0];
    if (rounded > sat_max) begin
      result = sat_max[DATA_WIDTH-1:0];
    end else if (rounded < sat_min) begin
      result = sat_min[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/avg_pool_accum.sv
// Accumulates 32 signed product lanes over a pooling window, then rounds/saturates to 8 bits.
// Result registered one cycle after the last beat; held in OUT until the consumer accepts it.
module avg_pool_accum
  import avg_pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int CNT_WIDTH   = 8,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic [CNT_WIDTH-1:0]                  i_win_len,
  input  logic [SHIFT_WIDTH-1:0]                i_shift,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [DATA_COPIES*2*DATA_WIDTH-1:0]   i_mul_result,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [DATA_COPIES*DATA_WIDTH-1:0]     o_pool_data,
  output logic                                  o_busy
);

  localparam int PROD_W = prod_width(DATA_WIDTH);

  pool_state_t              state;
  logic [CNT_WIDTH-1:0]     win_len_q;
  logic [SHIFT_WIDTH-1:0]   shift_q;
  logic [CNT_WIDTH-1:0]     beat_cnt;
  logic [ACC_WIDTH-1:0]     acc   [DATA_COPIES];
  logic [ACC_WIDTH-1:0]     sum_w [DATA_COPIES];
  logic [DATA_COPIES*DATA_WIDTH-1:0] pool_next;
  logic                     beat_fire;
  logic                     last_beat;

  assign beat_fire = (state == ST_ACC) && i_valid;
  assign last_beat = (beat_cnt == win_len_q - CNT_WIDTH'(1));

  for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
    logic [PROD_W-1:0] prod;

    assign prod     = i_mul_result[PROD_W*g +: PROD_W];
    assign sum_w[g] = acc[g] + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

    avg_pool_round_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_round_sat (
      .sum    (sum_w[g]),
      .shift  (shift_q),
      .result (pool_next[DATA_WIDTH*g +: DATA_WIDTH])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      win_len_q   <= '0;
      shift_q     <= '0;
      beat_cnt    <= '0;
      o_ready     <= 1'b0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_pool_data <= '0;
      for (int i = 0; i < DATA_COPIES; i++) begin
        acc[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            // A zero-length window degenerates to a single beat.
            win_len_q <= (i_win_len == '0) ? CNT_WIDTH'(1) : i_win_len;
            shift_q   <= i_shift;
            beat_cnt  <= '0;
            for (int i = 0; i < DATA_COPIES; i++) begin
              acc[i] <= '0;
            end
            state   <= ST_ACC;
            o_ready <= 1'b1;
            o_busy  <= 1'b1;
          end
        end

        ST_ACC: begin
          if (beat_fire) begin
            if (last_beat) begin
              o_pool_data <= pool_next;
              o_valid     <= 1'b1;
              o_ready     <= 1'b0;
              state       <= ST_OUT;
            end else begin
              for (int i = 0; i < DATA_COPIES; i++) begin
                acc[i] <= sum_w[i];
              end
              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
          end
        end

        ST_OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          o_ready <= 1'b0;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_pool_accum.sv
// Directed plus randomized windows against an arithmetic reference of the pooling rules.
module tb_avg_pool_accum;

  localparam int DW = 8;
  localparam int DC = 32;
  localparam int PW = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic [7:0]        i_win_len;
  logic [4:0]        i_shift;
  logic              i_valid;
  logic              o_ready;
  logic [DC*PW-1:0]  i_mul_result;
  logic              o_valid;
  logic              i_ready;
  logic [DC*DW-1:0]  o_pool_data;
  logic              o_busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  longint          lane_sum [DC];
  int              cur_shift;
  logic [DC*DW-1:0] exp_vec;
  logic [DC*PW-1:0] v;

  avg_pool_accum dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_win_len    (i_win_len),
    .i_shift      (i_shift),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_mul_result (i_mul_result),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_pool_data  (o_pool_data),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DC*DW-1:0] obs, input logic [DC*DW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DC; i++) lane_sum[i] = 0;
  endfunction

  function automatic void model_add(input logic [DC*PW-1:0] vec);
    for (int i = 0; i < DC; i++) lane_sum[i] += longint'($signed(vec[PW*i +: PW]));
  endfunction

  // Average = round-half-up of sum / 2^shift, clamped to the signed 8-bit range.
  function automatic logic [DC*DW-1:0] model_result(input int sh);
    logic [DC*DW-1:0] res;
    longint r;
    res = '0;
    for (int i = 0; i < DC; i++) begin
      if (sh == 0) r = lane_sum[i];
      else         r = (lane_sum[i] + (longint'(1) <<< (sh - 1))) >>> sh;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      res[DW*i +: DW] = r[7:0];
    end
    return res;
  endfunction

  task automatic do_start(input int len, input int sh);
    i_start   = 1'b1;
    i_win_len = 8'(len);
    i_shift   = 5'(sh);
    tick(1);
    i_start = 1'b0;
    check("start_ready", {255'd0, o_ready}, 256'd1);
    model_clear();
    cur_shift = sh;
  endtask

  task automatic send_beat(input logic [DC*PW-1:0] vec);
    bit accepted;
    accepted     = 1'b0;
    i_valid      = 1'b1;
    i_mul_result = vec;
    for (int k = 0; k < 20 && !accepted; k++) begin
      if (o_ready) accepted = 1'b1;
      tick(1);
    end
    i_valid = 1'b0;
    if (accepted) model_add(vec);
    else check("beat_accept_timeout", 256'd0, 256'd1);
  endtask

  task automatic finish_out(input string tag);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    check({tag, "_valid_cleared"}, {255'd0, o_valid}, 256'd0);
    check({tag, "_idle"}, {255'd0, o_busy}, 256'd0);
  endtask

  function automatic logic [DC*PW-1:0] lane0_vec(input int p);
    logic [DC*PW-1:0] r;
    r = '0;
    r[PW-1:0] = 16'(p);
    return r;
  endfunction

  initial begin
    int len, sh, gap;
    i_rst = 1'b1; i_start = 1'b0; i_win_len = '0; i_shift = '0;
    i_valid = 1'b0; i_mul_result = '0; i_ready = 1'b0;
    cur_shift = 0;
    model_clear();
    #2;
    check("rst_valid", {255'd0, o_valid}, 256'd0);
    check("rst_ready", {255'd0, o_ready}, 256'd0);
    check("rst_busy",  {255'd0, o_busy},  256'd0);
    check("rst_data",  o_pool_data,       256'd0);
    tick(2);
    i_rst = 1'b0;
    tick(1);

    // Positive window: (46 + 2) >> 2 = 12 in lane 0.
    do_start(4, 2);
    check("t1_busy", {255'd0, o_busy}, 256'd1);
    for (int b = 0; b < 4; b++) begin
      send_beat(lane0_vec(10 + b));
      if (b == 2) check("t1_no_early_valid", {255'd0, o_valid}, 256'd0);
    end
    check("t1_valid", {255'd0, o_valid}, 256'd1);
    check("t1_ready_low", {255'd0, o_ready}, 256'd0);
    check("t1_lane0", {248'd0, o_pool_data[7:0]}, 256'd12);
    check("t1_vec", o_pool_data, model_result(cur_shift));
    finish_out("t1");

    // Negative window: (-46 + 2) >>> 2 = -11; lane 31: (4 + 2) >> 2 = 1.
    do_start(4, 2);
    for (int b = 0; b < 4; b++) begin
      v = lane0_vec(-(10 + b));
      v[DC*PW-1 -: PW] = 16'd1;
      send_beat(v);
    end
    check("t2_valid", {255'd0, o_valid}, 256'd1);
    check("t2_lane0", {248'd0, o_pool_data[7:0]}, {248'd0, 8'hF5});
    check("t2_lane31", {248'd0, o_pool_data[255:248]}, 256'd1);
    check("t2_vec", o_pool_data, model_result(cur_shift));
    finish_out("t2");

    // Saturation at both ends.
    do_start(1, 0);
    v = '0;
    v[15:0]  = 16'd300;
    v[31:16] = 16'hFED4;
    v[47:32] = 16'd127;
    send_beat(v);
    check("t3_valid", {255'd0, o_valid}, 256'd1);
    check("t3_lanes", {232'd0, o_pool_data[23:0]}, {232'd0, 8'h7F, 8'h80, 8'h7F});
    check("t3_vec", o_pool_data, model_result(cur_shift));
    finish_out("t3");

    // Input gap mid-window and consumer stall in OUT.
    do_start(4, 2);
    send_beat(lane0_vec(10));
    send_beat(lane0_vec(11));
    tick(3);
    check("t4_gap_ready", {255'd0, o_ready}, 256'd1);
    send_beat(lane0_vec(12));
    send_beat(lane0_vec(13));
    exp_vec = model_result(cur_shift);
    check("t4_lane0", {248'd0, o_pool_data[7:0]}, 256'd12);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("t4_stall_valid", {255'd0, o_valid}, 256'd1);
      check("t4_stall_data", o_pool_data, exp_vec);
      check("t4_stall_ready", {255'd0, o_ready}, 256'd0);
    end
    finish_out("t4");

    // Reset mid-window discards the partial sums.
    do_start(4, 2);
    send_beat(lane0_vec(100));
    send_beat(lane0_vec(100));
    i_rst = 1'b1;
    #1;
    check("t5_rst_ready", {255'd0, o_ready}, 256'd0);
    check("t5_rst_busy",  {255'd0, o_busy},  256'd0);
    check("t5_rst_valid", {255'd0, o_valid}, 256'd0);
    tick(1);
    i_rst = 1'b0;
    check("t5_rst_data", o_pool_data, 256'd0);
    do_start(2, 1);
    send_beat(lane0_vec(4));
    send_beat(lane0_vec(6));
    check("t5_valid", {255'd0, o_valid}, 256'd1);
    check("t5_lane0", {248'd0, o_pool_data[7:0]}, 256'd5);
    finish_out("t5");

    // Zero window length behaves as one beat.
    do_start(0, 0);
    send_beat(lane0_vec(7));
    check("t6_valid", {255'd0, o_valid}, 256'd1);
    check("t6_lane0", {248'd0, o_pool_data[7:0]}, 256'd7);
    finish_out("t6");

    // A start pulse during accumulation must not restart or resize the window.
    do_start(3, 0);
    send_beat(lane0_vec(5));
    i_start = 1'b1; i_win_len = 8'd1; i_shift = 5'd3;
    tick(1);
    i_start = 1'b0;
    send_beat(lane0_vec(6));
    check("t7_no_early_valid", {255'd0, o_valid}, 256'd0);
    send_beat(lane0_vec(7));
    check("t7_valid", {255'd0, o_valid}, 256'd1);
    check("t7_lane0", {248'd0, o_pool_data[7:0]}, 256'd18);
    finish_out("t7");

    // Randomized windows across all lanes.
    for (int w = 0; w < 24; w++) begin
      len = $urandom_range(1, 6);
      sh  = (w == 5) ? 31 : $urandom_range(0, 12);
      do_start(len, sh);
      for (int b = 0; b < len; b++) begin
        gap = $urandom_range(0, 2);
        tick(gap);
        for (int i = 0; i < DC; i++) begin
          if ($urandom_range(0, 1) == 1) v[PW*i +: PW] = 16'($urandom);
          else v[PW*i +: PW] = 16'($signed($urandom_range(0, 600)) - 300);
        end
        send_beat(v);
      end
      exp_vec = model_result(cur_shift);
      check("rnd_valid", {255'd0, o_valid}, 256'd1);
      check("rnd_vec", o_pool_data, exp_vec);
      gap = $urandom_range(0, 3);
      tick(gap);
      check("rnd_hold", o_pool_data, exp_vec);
      finish_out("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
